// File: rtl/banco_regs_param_if.sv
// Bus bundle for banco_regs_param: read ports, write-back, issue scoreboard and dump stream.
// The master side drives addresses/commands; the slave side (register file) returns data.
interface banco_regs_param_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic            we;
    logic [AW-1:0]   rd;
    logic [1:0]      wb_sel;
    logic [XLEN-1:0] wdata_alu;
    logic [XLEN-1:0] wdata_mem;
    logic [XLEN-1:0] wdata_pc4;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            busy1;
    logic            busy2;
    logic            dump_start;
    logic            dump_valid;
    logic [AW-1:0]   dump_idx;
    logic [XLEN-1:0] dump_data;
    logic            dump_done;

    modport master (
        output rs1, rs2, we, rd, wb_sel, wdata_alu, wdata_mem, wdata_pc4,
               issue_valid, issue_rd, dump_start,
        input  rdata1, rdata2, busy1, busy2, dump_valid, dump_idx, dump_data, dump_done
    );

    modport slave (
        input  rs1, rs2, we, rd, wb_sel, wdata_alu, wdata_mem, wdata_pc4,
               issue_valid, issue_rd, dump_start,
        output rdata1, rdata2, busy1, busy2, dump_valid, dump_idx, dump_data, dump_done
    );
endinterface

// File: rtl/banco_regs_param.sv
// Parameterised register file with write-through reads, a per-register busy scoreboard
// and a sequential dump engine that streams every register out, one per cycle.
module banco_regs_param #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    banco_regs_param_if.slave   bus
);
    localparam int          AW   = $clog2(NREGS);
    localparam bit          ZR   = (ZERO_REG != 0);
    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } dump_state_e;

    logic [XLEN-1:0] r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;
    logic [XLEN-1:0] w_wdata;
    logic            w_wr;
    logic            w_issue;
    logic [AW-1:0]   w_rs    [2];
    logic [XLEN-1:0] w_rdata [2];

    dump_state_e     r_state;
    dump_state_e     w_state_nxt;
    logic [AW-1:0]   r_idx;
    logic [AW-1:0]   w_idx_nxt;
    logic            r_dump_valid;
    logic            r_dump_done;
    logic [AW-1:0]   r_dump_idx;
    logic [XLEN-1:0] r_dump_data;
    logic            w_dump_valid_nxt;
    logic            w_dump_done_nxt;
    logic [AW-1:0]   w_dump_idx_nxt;
    logic [XLEN-1:0] w_dump_data_nxt;

    always_comb begin
        // NOTE: default assignment first so every path drives w_wdata and no latch is inferred.
        w_wdata = '0;
        case (bus.wb_sel)
            2'b00:   w_wdata = bus.wdata_alu;
            2'b01:   w_wdata = bus.wdata_mem;
            2'b10:   w_wdata = bus.wdata_pc4;
            default: w_wdata = '0;
        endcase
    end

    // wb_sel=11 means "no write-back"; a hardwired zero register can neither be written nor owned.
    assign w_wr    = bus.we && (bus.wb_sel != 2'b11) && !(ZR && (bus.rd == '0));
    assign w_issue = bus.issue_valid && !(ZR && (bus.issue_rd == '0));

    always_ff @(posedge clk) begin
        // NOTE: the file must clear on reset, so it is built from flops rather than a RAM macro;
        // sequential state always uses <= so every flop samples pre-edge values.
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_wr) begin
            r_regs[bus.rd] <= w_wdata;
        end
    end

    assign w_rs[0] = bus.rs1;
    assign w_rs[1] = bus.rs2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            if (w_wr && (bus.rd == w_rs[p]))   w_rdata[p] = w_wdata;
            else if (ZR && (w_rs[p] == '0))    w_rdata[p] = '0;
            else                               w_rdata[p] = r_regs[w_rs[p]];
        end
    end

    assign bus.rdata1 = w_rdata[0];
    assign bus.rdata2 = w_rdata[1];

    // Set is applied after clear, so a same-index issue and write-back leave the new owner busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr)    w_busy_nxt[bus.rd]       = 1'b0;
        if (w_issue) w_busy_nxt[bus.issue_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_busy <= '0;
        else        r_busy <= w_busy_nxt;
    end

    assign bus.busy1 = r_busy[bus.rs1];
    assign bus.busy2 = r_busy[bus.rs2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_dump_valid <= 1'b0;
            r_dump_done  <= 1'b0;
            r_dump_idx   <= '0;
            r_dump_data  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_dump_valid <= w_dump_valid_nxt;
            r_dump_done  <= w_dump_done_nxt;
            r_dump_idx   <= w_dump_idx_nxt;
            r_dump_data  <= w_dump_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (bus.dump_start) begin
                    w_state_nxt = S_RUN;
                    w_idx_nxt   = '0;
                end
            end
            S_RUN: begin
                w_idx_nxt = r_idx + AW'(1);
                if (r_idx == LAST) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Beat data is the stored value, so a write on the same edge shows up only if not yet dumped.
    always_comb begin
        w_dump_valid_nxt = (r_state == S_RUN);
        w_dump_done_nxt  = (r_state == S_DONE);
        w_dump_idx_nxt   = r_dump_idx;
        w_dump_data_nxt  = r_dump_data;
        if (r_state == S_RUN) begin
            w_dump_idx_nxt  = r_idx;
            w_dump_data_nxt = r_regs[r_idx];
        end
    end

    assign bus.dump_valid = r_dump_valid;
    assign bus.dump_done  = r_dump_done;
    assign bus.dump_idx   = r_dump_idx;
    assign bus.dump_data  = r_dump_data;
endmodule

// File: doc/banco_regs_param.md
BANCO_REGS_PARAM -- requirements
Module: banco_regs_param

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter NREGS, default 32, register count; power of two, minimum 2; AW = log2(NREGS).
REQ-003 Parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero, 0 = register 0 writable.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 rs1, rs2  in  AW  read addresses.
REQ-007 rdata1, rdata2  out  XLEN  read data, combinational.
REQ-008 we  in  1  write-back enable.
REQ-009 rd  in  AW  write address.
REQ-010 wb_sel  in  2  write source: 00 wdata_alu, 01 wdata_mem, 10 wdata_pc4, 11 none.
REQ-011 wdata_alu, wdata_mem, wdata_pc4  in  XLEN  write-back candidates.
REQ-012 issue_valid  in  1  instruction issued with a pending destination.
REQ-013 issue_rd  in  AW  pending destination index.
REQ-014 busy1, busy2  out  1  scoreboard busy bit of rs1 / rs2, combinational.
REQ-015 dump_start  in  1  request a full register dump.
REQ-016 dump_valid  out  1  dump_idx/dump_data valid this cycle.
REQ-017 dump_idx  out  AW  index of dumped register.
REQ-018 dump_data  out  XLEN  dumped register value.
REQ-019 dump_done  out  1  one-cycle pulse after the last dump beat.

Function
REQ-020 Effective write (wr) = we AND wb_sel != 11 AND NOT (ZERO_REG=1 AND rd=0).
REQ-021 On wr, the selected source is stored into register rd at the rising edge.
REQ-022 Register 0 reads 0 at all times when ZERO_REG=1.
REQ-023 Reads are write-through: if wr and rd equals rsN, rdataN equals the selected write data in the same cycle; otherwise rdataN equals stored register rsN.
REQ-024 Scoreboard: one busy bit per register; issue_valid sets busy[issue_rd]; wr clears busy[rd]; index 0 is never set when ZERO_REG=1.
REQ-025 Issue and write to the same index in the same cycle: the bit ends set (new owner wins); different indices are both applied.
REQ-026 busyN reflects the stored bit only (no bypass of same-cycle set/clear).
REQ-027 Dump FSM states IDLE, RUN, DONE; IDLE to RUN on dump_start with internal index 0.
REQ-028 In RUN, every edge registers dump_valid=1, dump_idx=index, dump_data=stored value of register index before that edge's write; index increments.
REQ-029 After the beat for index NREGS-1, FSM enters DONE; DONE drives dump_valid=0, dump_done=1 for one cycle, then IDLE.
REQ-030 dump_start outside IDLE is ignored; a dump takes exactly NREGS valid beats, back-to-back, no stall.
REQ-031 Writes continue during a dump; a write to an already-dumped index is not reported again.

Reset
REQ-032 While rst_n=0 at an edge: all registers, all busy bits, dump_valid, dump_done, dump_idx, dump_data cleared to 0, FSM to IDLE.
REQ-033 Reset asserted mid-dump aborts the dump without a dump_done pulse; reset has priority over wr, issue_valid and dump_start.

Verification
REQ-034 Reset, then we=1, wb_sel=00, rd=5, wdata_alu=0xDEADBEEF, rs1=5 -> rdata1=0xDEADBEEF same cycle (bypass) and next cycle with we=0.
REQ-035 we=1, rd=0, wb_sel=01, wdata_mem=0x1234, ZERO_REG=1 -> rdata1 with rs1=0 stays 0; with ZERO_REG=0 it reads 0x1234 after the edge.
REQ-036 issue_valid=1, issue_rd=7 -> busy1=1 next cycle for rs1=7; later issue_rd=7 and wr rd=7 same cycle -> busy stays 1; wr alone -> busy 0.
REQ-037 wb_sel=11, we=1, rd=3, wdata_alu=0xFFFF -> register 3 unchanged, busy[3] unchanged.
REQ-038 dump_start with NREGS=32, registers preloaded reg[i]=i*4 -> 32 consecutive beats idx 0..31, data 0..124, then dump_done one cycle; second dump_start during RUN ignored.
REQ-039 rst_n=0 at beat 10 of a dump -> dump_valid 0 next cycle, no dump_done, all registers read 0.
